// File: rtl/fs_serial.sv
// Bit-serial subtractor: D = A - B - Bi computed LSB first over WIDTH
// cycles with a single full-subtractor cell and a registered borrow.
// Operands and results move through valid/ready handshakes.
module fs_serial #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             borrow_nxt;
    logic             last_step;
    logic [WIDTH:0]   d_cat;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Full-subtractor borrow out: borrow when a < b + c for this bit.
    function automatic logic fs_borrow(input logic a, input logic b, input logic c);
        return (~a & b) | (~(a ^ b) & c);
    endfunction

    assign a_bit      = ra[0];
    assign b_bit      = rb[0];
    assign d_bit      = fs_diff(a_bit, b_bit, borrow);
    assign borrow_nxt = fs_borrow(a_bit, b_bit, borrow);
    assign last_step  = (cnt == LAST);
    // New difference bit enters at the MSB while D moves right; works for WIDTH=1 too.
    assign d_cat      = {d_bit, D};

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        In_ready  = 1'b0;
        Out_valid = 1'b0;
        Busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Busy      = 1'b1;
                Out_valid = 1'b1;
                if (Out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow chain, bit counter and result registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ra     <= '0;
            rb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            Bo     <= 1'b0;
            V      <= 1'b0;
        end else if (accept) begin
            ra     <= A;
            rb     <= B;
            borrow <= Bi;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            ra     <= ra >> 1;
            rb     <= rb >> 1;
            borrow <= borrow_nxt;
            cnt    <= cnt + CW'(1);
            D      <= d_cat[WIDTH:1];
            if (last_step) begin
                // Signed overflow: borrow into the MSB differs from borrow out of it.
                V  <= borrow ^ borrow_nxt;
                Bo <= borrow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fs_serial.sv
// Self-checking bench for fs_serial: directed cases on WIDTH=8, then
// concurrent random regressions on WIDTH=8, 1 and 32 with a scoreboard.
module tb_fs_serial;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        v;
        int          acc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        in_valid[3];
    logic        in_ready[3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic        bi[3];
    logic        bo[3];
    logic        v[3];
    logic        busy[3];
    logic [31:0] a_s[3];
    logic [31:0] b_s[3];
    logic [31:0] d_s[3];
    logic [7:0]  d8;
    logic [0:0]  d1;
    logic [31:0] d32;

    exp_t sbq[3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    // Posedge counter used to measure accept-to-valid latency.
    always @(posedge Clk) cyc <= cyc + 1;

    always_comb begin
        d_s[0] = {24'd0, d8};
        d_s[1] = {31'd0, d1};
        d_s[2] = d32;
    end

    fs_serial #(.WIDTH(8)) u_w8 (
        .Clk(Clk), .Rst_n(Rst_n), .In_valid(in_valid[0]), .In_ready(in_ready[0]),
        .A(a_s[0][7:0]), .B(b_s[0][7:0]), .Bi(bi[0]), .Out_valid(out_valid[0]),
        .Out_ready(out_ready[0]), .D(d8), .Bo(bo[0]), .V(v[0]), .Busy(busy[0])
    );

    fs_serial #(.WIDTH(1)) u_w1 (
        .Clk(Clk), .Rst_n(Rst_n), .In_valid(in_valid[1]), .In_ready(in_ready[1]),
        .A(a_s[1][0:0]), .B(b_s[1][0:0]), .Bi(bi[1]), .Out_valid(out_valid[1]),
        .Out_ready(out_ready[1]), .D(d1), .Bo(bo[1]), .V(v[1]), .Busy(busy[1])
    );

    fs_serial #(.WIDTH(32)) u_w32 (
        .Clk(Clk), .Rst_n(Rst_n), .In_valid(in_valid[2]), .In_ready(in_ready[2]),
        .A(a_s[2]), .B(b_s[2]), .Bi(bi[2]), .Out_valid(out_valid[2]),
        .Out_ready(out_ready[2]), .D(d32), .Bo(bo[2]), .V(v[2]), .Busy(busy[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Arithmetic reference: integer subtraction, unsigned compare, signed range test.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bin);
        exp_t   e;
        longint m, ua, ub, sa, sb, r;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        e.d  = 32'((ua - ub - longint'(bin)) & (m - 1));
        e.bo = (ua < ub + longint'(bin));
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sa - sb - longint'(bin);
        e.v   = (r < -(m / 2)) || (r > (m / 2) - 1);
        e.acc = 0;
        return e;
    endfunction

    // Present operands, wait for acceptance, push the expected result.
    task automatic send(input int k, input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic bin);
        exp_t e;
        int   guard = 0;
        a_s[k] = a;
        b_s[k] = b;
        bi[k]  = bin;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && guard < 300) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 300) begin
            chk("accept_timeout", in_ready[k], 1);
            in_valid[k] = 1'b0;
            return;
        end
        e = model(w, a, b, bin);
        e.acc = cyc + 1;
        sbq[k].push_back(e);
        @(negedge Clk);
        in_valid[k] = 1'b0;
    endtask

    // Wait for Out_valid, compare against the scoreboard head, let the handshake edge pass.
    task automatic collect(input int k, input int w, input bit chk_rdy);
        exp_t e;
        int   guard = 0;
        while (!out_valid[k] && guard < 100) begin
            if (chk_rdy) chk("in_ready_busy", in_ready[k], 0);
            @(negedge Clk);
            guard++;
        end
        chk("valid_seen", out_valid[k], 1);
        chk("sb_nonempty", sbq[k].size() != 0, 1);
        if (sbq[k].size() != 0) begin
            e = sbq[k].pop_front();
            chk("latency", cyc - e.acc, w);
            chk("d", d_s[k], e.d);
            chk("bo", bo[k], e.bo);
            chk("v", v[k], e.v);
        end
        @(negedge Clk);
    endtask

    task automatic rand_drive(input int k, input int w, input int n);
        int sent = 0;
        while (sent < n) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid[k] = 1'b0;
                @(negedge Clk);
            end else begin
                send(k, w, $urandom, $urandom, 1'($urandom_range(0, 1)));
                sent++;
            end
        end
    endtask

    task automatic rand_monitor(input int k, input int w, input int n);
        exp_t e;
        int   got = 0;
        int   guard = 0;
        bit   prev = 1'b0;
        while (got < n) begin
            @(negedge Clk);
            guard++;
            if (guard > n * (w + 12) + 200) begin
                chk("rand_timeout", got, n);
                break;
            end
            if (out_valid[k] && !prev) begin
                chk("rand_sb_nonempty", sbq[k].size() != 0, 1);
                if (sbq[k].size() != 0) begin
                    e = sbq[k][0];
                    chk("rand_latency", cyc - e.acc, w);
                    chk("rand_d", d_s[k], e.d);
                    chk("rand_bo", bo[k], e.bo);
                    chk("rand_v", v[k], e.v);
                end
            end
            prev = out_valid[k];
            out_ready[k] = ($urandom_range(0, 3) != 0);
            if (out_valid[k] && out_ready[k]) begin
                if (sbq[k].size() != 0) void'(sbq[k].pop_front());
                got++;
                prev = 1'b0;
            end
        end
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic bin);
        send(0, 8, a, b, bin);
        collect(0, 8, 1'b1);
    endtask

    initial begin
        exp_t e;
        int   guard;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            a_s[k] = '0;
            b_s[k] = '0;
            bi[k]  = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_d", d_s[0], 0);
        chk("rst_bo", bo[0], 0);
        chk("rst_v", v[0], 0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Directed arithmetic cases
        run_one(32'h5A, 32'h3C, 1'b0);
        run_one(32'h00, 32'h01, 1'b0);
        run_one(32'h10, 32'h10, 1'b1);
        run_one(32'h80, 32'h01, 1'b0);
        run_one(32'h7F, 32'hFF, 1'b0);

        // Backpressure with new operands held on In_valid during DONE
        out_ready[0] = 1'b0;
        send(0, 8, 32'h5A, 32'h3C, 1'b0);
        guard = 0;
        while (!out_valid[0] && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        chk("bp_valid_seen", out_valid[0], 1);
        e = sbq[0].pop_front();
        chk("bp_latency", cyc - e.acc, 8);
        a_s[0] = 32'h33;
        b_s[0] = 32'h11;
        bi[0]  = 1'b0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_d", d_s[0], e.d);
            chk("bp_bo", bo[0], e.bo);
            chk("bp_v", v[0], e.v);
            @(negedge Clk);
        end
        out_ready[0] = 1'b1;
        @(negedge Clk);
        chk("bp_idle_in_ready", in_ready[0], 1);
        chk("bp_idle_out_valid", out_valid[0], 0);
        e = model(8, 32'h33, 32'h11, 1'b0);
        e.acc = cyc + 1;
        sbq[0].push_back(e);
        @(negedge Clk);
        in_valid[0] = 1'b0;
        chk("bp_accepted_busy", busy[0], 1);
        collect(0, 8, 1'b1);

        // Reset in the 4th SHIFT cycle discards the operation
        send(0, 8, 32'h5A, 32'h3C, 1'b0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        void'(sbq[0].pop_back());
        chk("mid_rst_in_ready", in_ready[0], 1);
        chk("mid_rst_out_valid", out_valid[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_d", d_s[0], 0);
        chk("mid_rst_bo", bo[0], 0);
        chk("mid_rst_v", v[0], 0);
        run_one(32'h5A, 32'h3C, 1'b0);

        // Random regressions on all three widths in parallel
        fork
            rand_drive(0, 8, 1000);
            rand_monitor(0, 8, 1000);
            rand_drive(1, 1, 1000);
            rand_monitor(1, 1, 1000);
            rand_drive(2, 32, 1000);
            rand_monitor(2, 32, 1000);
        join
        for (int k = 0; k < 3; k++) chk("sb_drained", sbq[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
